time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Control stage directly upstream of the clock's seconds/minutes/hours counters. Generates the 1 Hz count enable for the seconds counter and converts two raw push-buttons (mode, increment) into the per-counter `load`/`data` strobes used to set the time. Counters keep their own carry chain. This block drives only the seconds enable and the three load strobes, and gates counting off while the time is being set.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clk cycles per seconds tick. Must be at least 2.
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles required to accept a button change. Must be at least 1.
- `BLINK_DIV`, default 12_500_000: clk cycles per `blink` toggle. Must be at least 1.

Ports:
- `clk` in 1: single system clock. All logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_mode` in 1: raw mode button, asynchronous to `clk`, active-high.
- `btn_inc` in 1: raw increment button, asynchronous to `clk`, active-high.
- `cur_hr` in 5: current hours counter value (0–23).
- `cur_min` in 6: current minutes counter value (0–59).
- `cur_sec` in 6: current seconds counter value (0–59).
- `sec_en` out 1: one-cycle count enable to the seconds counter.
- `hr_load` out 1: one-cycle load strobe to the hours counter.
- `min_load` out 1: one-cycle load strobe to the minutes counter.
- `sec_load` out 1: one-cycle load strobe to the seconds counter.
- `load_data` out 6: value for whichever load strobe is active. Hours use bits [4:0], and bit 5 is 0.
- `mode` out 2: 0 = RUN, 1 = SET_HR, 2 = SET_MIN, 3 = SET_SEC.
- `blink` out 1: display blink phase for the field being edited. It is 0 in RUN.

## Operation
- **Button front end (per button):** 2-FF synchronizer, then a debouncer.
  - The debounce counter increments while the synced level differs from the debounced level, and clears when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level takes the synced level and the counter clears.
  - A registered rising-edge detector on the debounced level gives a one-cycle press pulse (`p_mode`, `p_inc`). Releases produce no pulse.
- **FSM**, states RUN → SET_HR → SET_MIN → SET_SEC → RUN. It advances only on `p_mode`.
  - On entry to SET_HR, SET_MIN or SET_SEC, the 6-bit edit register captures `cur_hr`, `cur_min` or `cur_sec` respectively.
  - `p_inc` in a SET state: edit becomes edit+1. It wraps 23→0 in SET_HR and 59→0 in SET_MIN/SET_SEC.
  - `p_inc` in RUN is ignored.
- **Load:** on the cycle after an accepted `p_inc`:
  - the matching `*_load` is 1 for exactly one cycle;
  - `load_data` equals the new edit value.
  - At most one load strobe is high in any cycle. `load_data` is 0 whenever no load is active.
  - Values driven on `load_data` are always in range (≤23 for hours, ≤59 otherwise).
- **Prescaler:** counts 0..`TICK_DIV`-1 and wraps.
  - `sec_en` is 1 for one cycle when the count wraps, only while in RUN.
  - The prescaler is held at 0 in every SET state, so the first tick after returning to RUN comes a full `TICK_DIV` cycles later.
- **Blink:** a counter runs only in SET states and toggles `blink` every `BLINK_DIV` cycles. Counter and `blink` are forced to 0 in RUN and on each state change.
- **Simultaneous `p_mode` and `p_inc`:** mode wins and the increment is discarded. No load strobe is issued.
- **No load with enable:** `sec_en` and any `*_load` are never high in the same cycle.

## Timing
- **Reset values:** after reset deasserts (async, may occur mid-edit), all of the following hold:
  - state RUN, `mode`=0;
  - `sec_en`, `hr_load`, `min_load`, `sec_load`, `blink` = 0, and `load_data`=0;
  - prescaler, debounce counters, debounced levels and edit register = 0.
- All outputs are registered.
- **Button latency:** a raw level change held stable reaches the press pulse in 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge) cycles. Bounces shorter than `DEBOUNCE_CYCLES` produce no pulse.
- **`p_mode` at cycle N:** `mode` and the edit register update at N+1.
- **`p_inc` at cycle N:** edit register, `*_load` and `load_data` are valid at N+1. The load strobe falls at N+2.
- **Tick timing in RUN:** `sec_en` pulses every `TICK_DIV` cycles, the first one `TICK_DIV` cycles after reset release.
- **Leaving SET_SEC at cycle N** (`mode`=0 at N+1): the next `sec_en` is at N+1+`TICK_DIV`.
- **Counter carry timing:** `p_inc` loads never depend on counter carry. If a downstream carry occurs in the same cycle as a load, it has no effect on this block.

## Test plan
Bench parameters: `TICK_DIV`=10, `DEBOUNCE_CYCLES`=4, `BLINK_DIV`=3.
- **Reset and ticking:** release reset and hold buttons low. `sec_en` pulses at cycles 10, 20, 30, and all loads stay 0. Assert `rst_n` mid-count: outputs go 0 immediately and the tick period restarts.
- **Debounce:** `btn_inc` 3-cycle glitch → no pulse. `btn_mode` held 20 cycles → `mode` becomes 1 exactly 7 cycles after the rising edge. Release → no state change.
- **Hour edit wrap:** set `cur_hr`=22, enter SET_HR, give 2 clean inc presses. `hr_load` pulses with `load_data`=23, then with `load_data`=0. `sec_en` stays 0 throughout.
- **Minute/second wrap:**
  - SET_MIN with `cur_min`=59 plus one inc → `min_load` with `load_data`=59→0.
  - SET_SEC with `cur_sec`=10 plus one inc → `sec_load` with `load_data`=11.
- **Full cycle and return:** mode pressed 4 times → `mode` goes 1, 2, 3, 0. `blink` toggles every 3 cycles in set states and is 0 in RUN. The first `sec_en` comes 10 cycles after `mode`=0.
- **Simultaneous presses:** force `p_mode` and `p_inc` in the same cycle in SET_HR. `mode` goes to 2, and no `*_load` pulses.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Time-set control for the clock counters: 1 Hz seconds enable, button debouncing,
// and the RUN/SET_HR/SET_MIN/SET_SEC edit FSM that issues per-counter load strobes.
module time_set_ctrl #(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned BLINK_DIV       = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       sec_en,
  output logic       hr_load,
  output logic       min_load,
  output logic       sec_load,
  output logic [5:0] load_data,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    sync1, sync2, deb, deb_q, press;
  logic [DW-1:0] dcnt [2];
  logic          p_mode, p_inc;
  logic [5:0]    edit, edit_nx, edit_inc, data_nx;
  logic          hr_nx, min_nx, sec_ld_nx;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;

  // Index 0 is the mode button, index 1 the increment button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_q   <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= {btn_inc, btn_mode};
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign press  = deb & ~deb_q;
  assign p_mode = press[0];
  assign p_inc  = press[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      edit      <= '0;
      hr_load   <= 1'b0;
      min_load  <= 1'b0;
      sec_load  <= 1'b0;
      load_data <= '0;
    end else begin
      state     <= state_nx;
      edit      <= edit_nx;
      hr_load   <= hr_nx;
      min_load  <= min_nx;
      sec_load  <= sec_ld_nx;
      load_data <= data_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    edit_nx   = edit;
    hr_nx     = 1'b0;
    min_nx    = 1'b0;
    sec_ld_nx = 1'b0;
    data_nx   = '0;
    // Wrap on >= limit so an out-of-range captured value still loads a legal one.
    if (state == SET_HR) edit_inc = (edit >= 6'd23) ? 6'd0 : edit + 6'd1;
    else                 edit_inc = (edit >= 6'd59) ? 6'd0 : edit + 6'd1;
    if (p_mode) begin
      case (state)
        RUN:     begin state_nx = SET_HR;  edit_nx = {1'b0, cur_hr}; end
        SET_HR:  begin state_nx = SET_MIN; edit_nx = cur_min;        end
        SET_MIN: begin state_nx = SET_SEC; edit_nx = cur_sec;        end
        default: state_nx = RUN;
      endcase
    end else if (p_inc && state != RUN) begin
      edit_nx = edit_inc;
      data_nx = edit_inc;
      case (state)
        SET_HR:  hr_nx     = 1'b1;
        SET_MIN: min_nx    = 1'b1;
        default: sec_ld_nx = 1'b1;
      endcase
    end
  end

  assign mode = state;

  // Prescaler is held at 0 outside RUN so ticking restarts cleanly on return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      sec_en   <= 1'b0;
    end else if (state != RUN) begin
      tick_cnt <= '0;
      sec_en   <= 1'b0;
    end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
      sec_en   <= ~p_mode;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      sec_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (state == RUN || p_mode) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: load events are scoreboarded against
// expectations pushed when each button press is driven.
module tb_time_set_ctrl;

  localparam int unsigned TD = 10;
  localparam int unsigned DB = 4;
  localparam int unsigned BD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hr = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic       sec_en, hr_load, min_load, sec_load, blink;
  logic [5:0] load_data;
  logic [1:0] mode;

  time_set_ctrl #(
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB),
    .BLINK_DIV      (BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .cur_hr   (cur_hr),
    .cur_min  (cur_min),
    .cur_sec  (cur_sec),
    .sec_en   (sec_en),
    .hr_load  (hr_load),
    .min_load (min_load),
    .sec_load (sec_load),
    .load_data(load_data),
    .mode     (mode),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [5:0]  data;
    int unsigned at;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          tests = 0;
  int          fails = 0;
  int          viol = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every load strobe observed and counts cycles that break the output rules.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hr_load)  obs_q.push_back('{kind: 2'd1, data: load_data, at: cyc});
      if (min_load) obs_q.push_back('{kind: 2'd2, data: load_data, at: cyc});
      if (sec_load) obs_q.push_back('{kind: 2'd3, data: load_data, at: cyc});
      if (int'(hr_load) + int'(min_load) + int'(sec_load) > 1) viol++;
      if (!(hr_load || min_load || sec_load) && load_data != 6'd0) viol++;
      if (hr_load && load_data > 6'd23) viol++;
      if ((min_load || sec_load) && load_data > 6'd59) viol++;
      if (sec_en && (hr_load || min_load || sec_load)) viol++;
      if (sec_en && mode != 2'd0) viol++;
      if (mode == 2'd0 && blink) viol++;
    end
  end

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    repeat (8) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_loads(input string name);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL %s: got no load, required kind %0d data %0d at cycle %0d",
                 name, e.kind, e.data, e.at);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.at !== e.at) begin
          fails++;
          $display("FAIL %s: got kind %0d data %0d at %0d, required kind %0d data %0d at %0d",
                   name, o.kind, o.data, o.at, e.kind, e.data, e.at);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d unexpected load events, required 0", name, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({sec_en, hr_load, min_load, sec_load, blink, mode, load_data} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %b, required all zero",
               {sec_en, hr_load, min_load, sec_load, blink, mode, load_data});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      tests++;
      if (sec_en !== ((k % TD) == 0)) begin
        fails++;
        $display("FAIL tick_k%0d: got sec_en %b, required %b", k, sec_en, (k % TD) == 0);
      end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sec_en, mode, blink, load_data} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %b, required all zero", {sec_en, mode, blink, load_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      tests++;
      if (sec_en !== (k == 10)) begin
        fails++;
        $display("FAIL tick_restart_k%0d: got sec_en %b, required %b", k, sec_en, k == 10);
      end
    end
    check_loads("idle_loads");
  endtask

  task automatic test_debounce;
    cur_hr = 5'd5;
    btn_mode = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 6 || k == 7) begin
        tests++;
        if (mode !== ((k == 7) ? 2'd1 : 2'd0)) begin
          fails++;
          $display("FAIL mode_latency_k%0d: got mode %0d, required %0d", k, mode, (k == 7) ? 1 : 0);
        end
      end
    end
    btn_mode = 1'b0;
    repeat (15) @(negedge clk);
    tests++;
    if (mode !== 2'd1) begin
      fails++;
      $display("FAIL release_no_change: got mode %0d, required 1", mode);
    end
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (15) @(negedge clk);
    check_loads("inc_glitch");
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mode, blink, hr_load, load_data} !== '0) begin
      fails++;
      $display("FAIL reset_mid_edit: got %b, required all zero", {mode, blink, hr_load, load_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hour_wrap;
    cur_hr = 5'd22;
    press(1'b1, 1'b0);
    tests++;
    if (mode !== 2'd1) begin
      fails++;
      $display("FAIL enter_set_hr: got mode %0d, required 1", mode);
    end
    exp_q.push_back('{kind: 2'd1, data: 6'd23, at: cyc + 7});
    press(1'b0, 1'b1);
    exp_q.push_back('{kind: 2'd1, data: 6'd0, at: cyc + 7});
    press(1'b0, 1'b1);
    check_loads("hr_wrap");
  endtask

  task automatic test_min_sec_wrap;
    cur_min = 6'd59;
    press(1'b1, 1'b0);
    tests++;
    if (mode !== 2'd2) begin
      fails++;
      $display("FAIL enter_set_min: got mode %0d, required 2", mode);
    end
    exp_q.push_back('{kind: 2'd2, data: 6'd0, at: cyc + 7});
    press(1'b0, 1'b1);
    cur_sec = 6'd10;
    press(1'b1, 1'b0);
    tests++;
    if (mode !== 2'd3) begin
      fails++;
      $display("FAIL enter_set_sec: got mode %0d, required 3", mode);
    end
    exp_q.push_back('{kind: 2'd3, data: 6'd11, at: cyc + 7});
    press(1'b0, 1'b1);
    check_loads("min_sec_wrap");
    press(1'b1, 1'b0);
    tests++;
    if (mode !== 2'd0) begin
      fails++;
      $display("FAIL back_to_run: got mode %0d, required 0", mode);
    end
  endtask

  task automatic test_full_cycle;
    logic [1:0] exp_mode [4];
    logic       exp_blink;
    exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int p = 0; p < 4; p++) begin
      btn_mode = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 8) btn_mode = 1'b0;
        if (k >= 7) begin
          tests++;
          if (mode !== exp_mode[p]) begin
            fails++;
            $display("FAIL cycle_mode_p%0d_k%0d: got %0d, required %0d", p, k, mode, exp_mode[p]);
          end
        end
        if (k >= 7 || p == 0) begin
          exp_blink = (k >= 7 && p < 3) ? ((((k - 7) / 3) % 2) == 1) : 1'b0;
          tests++;
          if (blink !== exp_blink) begin
            fails++;
            $display("FAIL blink_p%0d_k%0d: got %b, required %b", p, k, blink, exp_blink);
          end
        end
        if (k >= 7 || p != 0) begin
          tests++;
          if (sec_en !== (p == 3 && k == 17)) begin
            fails++;
            $display("FAIL return_tick_p%0d_k%0d: got %b, required %b", p, k, sec_en, p == 3 && k == 17);
          end
        end
      end
    end
    check_loads("full_cycle");
  endtask

  task automatic test_simultaneous;
    cur_hr = 5'd3;
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    tests++;
    if (mode !== 2'd2) begin
      fails++;
      $display("FAIL simul_mode: got mode %0d, required 2", mode);
    end
    check_loads("simul_no_load");
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    tests++;
    if (mode !== 2'd0) begin
      fails++;
      $display("FAIL simul_return: got mode %0d, required 0", mode);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_debounce();
    test_hour_wrap();
    test_min_sec_wrap();
    test_full_cycle();
    test_simultaneous();
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL output_rules: got %0d violating cycles, required 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
